branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Parametrised successor to the pipeline's combinational branch-condition logic.
- Evaluates all RV32 branch/jump conditions for configurable XLEN.
- Adds a direct-mapped branch history table (BHT) of 2-bit saturating counters. The IF stage reads it for a taken prediction.
- The EX stage resolves branches. A registered TAKEN/MISPREDICT result is returned one cycle later for PC redirect and flush.

Parameters:
- XLEN, 32, operand width of DATA1/DATA2 and PC width.
- BHT_DEPTH, 64, number of 2-bit counters; power of two, ≥2.
- IDX_LSB, 2, lowest PC bit used for the BHT index; index = PC[IDX_LSB +: log2(BHT_DEPTH)].

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  synchronous active-low reset.
- PRED_PC  in  XLEN  IF-stage PC to predict.
- PRED_TAKEN  out  1  combinational prediction: counter[idx(PRED_PC)][1].
- RES_VALID  in  1  EX-stage resolve request this cycle.
- RES_PC  in  XLEN  PC of the instruction being resolved.
- BRANCH_JUMP  in  3  op: 000 BEQ, 001 BNE, 010 NONE, 011 JUMP, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- DATA1, DATA2  in  XLEN each  rs1/rs2 operands.
- RES_PRED_TAKEN  in  1  prediction carried down the pipe with the instruction.
- FLUSH  in  1  kill the current resolve request.
- RES_DONE  out  1  registered: result valid.
- PC_SEL_OUT  out  1  registered: branch/jump taken.
- MISPREDICT  out  1  registered: PC_SEL_OUT != RES_PRED_TAKEN.

Behaviour:
- Reset (RESET_N=0 at an edge):
  - All BHT counters become 01 (weakly not-taken).
  - RES_DONE, PC_SEL_OUT and MISPREDICT become 0.
  - Reset asserted mid-operation discards any in-flight result. No update is applied that cycle.
- Condition evaluation (combinational, internal):
  - eq: DATA1==DATA2.
  - slt: signed compare, used for ops 100/101.
  - ult: unsigned compare, used for ops 110/111.
  - BGE/BGEU are taken when !lt, which includes equal.
  - JUMP is always taken. NONE is never taken.
- Accept condition: acc = RES_VALID & !FLUSH & (BRANCH_JUMP != 010).
- Latency: 1 cycle. At the edge following an acc cycle:
  - RES_DONE=1.
  - PC_SEL_OUT = taken.
  - MISPREDICT = taken ^ RES_PRED_TAKEN.
- When acc=0, the next cycle has RES_DONE=0 and PC_SEL_OUT=MISPREDICT=0.
- No stall input: the producer must hold RES_VALID low while EX is stalled.
- BHT update at the same edge, only when acc and the op is conditional (BRANCH_JUMP != 011):
  - Indexed counter saturating-increments if taken, saturating-decrements if not.
  - Saturation: 11 stays 11 on taken; 00 stays 00 on not-taken.
  - JUMP never updates the table.
- Read/write collision (idx(PRED_PC)==idx(RES_PC) in an updating cycle): PRED_TAKEN shows the pre-update value. No bypass.
- FLUSH together with RES_VALID: flush wins, giving no result and no update.
- Aliasing: PCs with the same index share a counter. No tags.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - BR_COUNT (32): counts accepted conditional branches.
  - MISP_COUNT (32): counts accepted ops with MISPREDICT=1.
  - Both saturate at 0xFFFF_FFFF, reset to 0, and update on the same edge as RES_DONE.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package bru_pkg holds:
  - Op encodings: BJ_BEQ..BJ_BGEU, BJ_NONE, BJ_JUMP.
  - Counter constants: SNT=00, WNT=01, WT=10, ST=11.
  - A function computing the saturating counter next state.
- Sub-module bht_table holds the counter array, the combinational read port and the synchronous reset/update write port. It is parametrised by BHT_DEPTH and IDX_LSB.

Test Plan:
- Reset then PRED_PC=0x0000_0040 → PRED_TAKEN=0. Resolve BLT at RES_PC=0x40, DATA1=0xFFFF_FFFF, DATA2=1, RES_PRED_TAKEN=0 → next cycle RES_DONE=1, PC_SEL_OUT=1, MISPREDICT=1; PRED_TAKEN for 0x40 becomes 1 (counter 10).
- Same operands with BLTU → PC_SEL_OUT=0. BGEU → PC_SEL_OUT=1. BGE with DATA1=DATA2=5 → PC_SEL_OUT=1.
- Resolve BEQ taken 3× at 0x80 → counter 01→10→11→11 (saturation). Then one not-taken → 10, PRED_TAKEN stays 1.
- JUMP with RES_PRED_TAKEN=0 → PC_SEL_OUT=1, MISPREDICT=1; BHT entry unchanged. Op NONE with RES_VALID=1 → RES_DONE=0.
- RES_VALID=1 with FLUSH=1 on taken BNE → RES_DONE=0, counter unchanged. Collision: PRED_PC=RES_PC=0x40 in the update cycle → PRED_TAKEN shows the old value, and the new value the following cycle.
- RESET_N low for one cycle after training entries to 11 → all PRED_TAKEN=0 and outputs 0. With BRU_PERF_CNT_EN, BR_COUNT=MISP_COUNT=0 after reset, and after 4 mispredicting branches both equal 4.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared encodings and counter helper for the branch resolve unit.
// Used by bht_table and branch_resolve_unit.
package bru_pkg;

    typedef enum logic [2:0] {
        BJ_BEQ  = 3'b000,
        BJ_BNE  = 3'b001,
        BJ_NONE = 3'b010,
        BJ_JUMP = 3'b011,
        BJ_BLT  = 3'b100,
        BJ_BGE  = 3'b101,
        BJ_BLTU = 3'b110,
        BJ_BGEU = 3'b111
    } bj_op_e;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic [1:0] ctr_next(
        input logic [1:0] cur,
        input logic       taken
    );
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = cur + 2'd1;
        end else begin
            if (cur != SNT) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Direct-mapped table of 2-bit saturating counters.
// Combinational read port, synchronous reset/update write port.
import bru_pkg::*;

module bht_table #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int IDX_LSB   = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_rd_pc,
    output logic            o_rd_taken,
    input  logic            i_wr_en,
    input  logic [XLEN-1:0] i_wr_pc,
    input  logic            i_wr_taken
);

    localparam int IW = $clog2(BHT_DEPTH);

    logic [1:0]    r_ctr [BHT_DEPTH];
    logic [IW-1:0] w_rd_idx;
    logic [IW-1:0] w_wr_idx;
    logic          w_unused_pc;

    assign w_rd_idx    = i_rd_pc[IDX_LSB +: IW];
    assign w_wr_idx    = i_wr_pc[IDX_LSB +: IW];
    assign w_unused_pc = ^{i_rd_pc, i_wr_pc};

    // No write-to-read bypass: a colliding read sees the old counter.
    assign o_rd_taken = r_ctr[w_rd_idx][1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_ctr[i] <= WNT;
            end
        end else if (i_wr_en) begin
            r_ctr[w_wr_idx] <= ctr_next(r_ctr[w_wr_idx], i_wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch/jump condition resolve with BHT predictor and registered redirect.
// Optional perf counters (BR_COUNT/MISP_COUNT) under BRU_PERF_CNT_EN.
import bru_pkg::*;

module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int IDX_LSB   = 2
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [XLEN-1:0] PRED_PC,
    output logic            PRED_TAKEN,
    input  logic            RES_VALID,
    input  logic [XLEN-1:0] RES_PC,
    input  logic [2:0]      BRANCH_JUMP,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            RES_PRED_TAKEN,
    input  logic            FLUSH,
`ifdef BRU_PERF_CNT_EN
    output logic [31:0]     BR_COUNT,
    output logic [31:0]     MISP_COUNT,
`endif
    output logic            RES_DONE,
    output logic            PC_SEL_OUT,
    output logic            MISPREDICT
);

    logic w_eq;
    logic w_slt;
    logic w_ult;
    logic w_taken;
    logic w_acc;
    logic w_upd;
    logic w_misp;
    logic r_done;
    logic r_sel;
    logic r_misp;

    assign w_eq  = (DATA1 == DATA2);
    assign w_slt = ($signed(DATA1) < $signed(DATA2));
    assign w_ult = (DATA1 < DATA2);

    always_comb begin
        w_taken = 1'b0;
        unique case (bj_op_e'(BRANCH_JUMP))
            BJ_BEQ:  w_taken = w_eq;
            BJ_BNE:  w_taken = !w_eq;
            BJ_NONE: w_taken = 1'b0;
            BJ_JUMP: w_taken = 1'b1;
            BJ_BLT:  w_taken = w_slt;
            BJ_BGE:  w_taken = !w_slt;
            BJ_BLTU: w_taken = w_ult;
            BJ_BGEU: w_taken = !w_ult;
            default: w_taken = 1'b0;
        endcase
    end

    // Flush dominates valid; NONE is never a resolve.
    assign w_acc  = RES_VALID && !FLUSH
                 && (bj_op_e'(BRANCH_JUMP) != BJ_NONE);
    assign w_upd  = w_acc && (bj_op_e'(BRANCH_JUMP) != BJ_JUMP);
    assign w_misp = w_taken ^ RES_PRED_TAKEN;

    bht_table #(
        .XLEN      (XLEN),
        .BHT_DEPTH (BHT_DEPTH),
        .IDX_LSB   (IDX_LSB)
    ) u_bht (
        .i_clk      (CLK),
        .i_rst_n    (RESET_N),
        .i_rd_pc    (PRED_PC),
        .o_rd_taken (PRED_TAKEN),
        .i_wr_en    (w_upd),
        .i_wr_pc    (RES_PC),
        .i_wr_taken (w_taken)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_done <= 1'b0;
            r_sel  <= 1'b0;
            r_misp <= 1'b0;
        end else begin
            r_done <= w_acc;
            r_sel  <= w_acc && w_taken;
            r_misp <= w_acc && w_misp;
        end
    end

    assign RES_DONE   = r_done;
    assign PC_SEL_OUT = r_sel;
    assign MISPREDICT = r_misp;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] r_br_cnt;
    logic [31:0] r_misp_cnt;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_br_cnt   <= '0;
            r_misp_cnt <= '0;
        end else begin
            if (w_upd && (r_br_cnt != '1)) begin
                r_br_cnt <= r_br_cnt + 32'd1;
            end
            if (w_acc && w_misp && (r_misp_cnt != '1)) begin
                r_misp_cnt <= r_misp_cnt + 32'd1;
            end
        end
    end

    assign BR_COUNT   = r_br_cnt;
    assign MISP_COUNT = r_misp_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a cycle model and scoreboard.
// Build with +define+BRU_PERF_CNT_EN to also check the perf counters.
module tb_branch_resolve_unit;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [31:0] PRED_PC = '0;
    logic        PRED_TAKEN;
    logic        RES_VALID = 1'b0;
    logic [31:0] RES_PC = '0;
    logic [2:0]  BRANCH_JUMP = 3'b010;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic        RES_PRED_TAKEN = 1'b0;
    logic        FLUSH = 1'b0;
    logic        RES_DONE;
    logic        PC_SEL_OUT;
    logic        MISPREDICT;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] BR_COUNT;
    logic [31:0] MISP_COUNT;
`endif

    branch_resolve_unit dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .PRED_PC        (PRED_PC),
        .PRED_TAKEN     (PRED_TAKEN),
        .RES_VALID      (RES_VALID),
        .RES_PC         (RES_PC),
        .BRANCH_JUMP    (BRANCH_JUMP),
        .DATA1          (DATA1),
        .DATA2          (DATA2),
        .RES_PRED_TAKEN (RES_PRED_TAKEN),
        .FLUSH          (FLUSH),
`ifdef BRU_PERF_CNT_EN
        .BR_COUNT       (BR_COUNT),
        .MISP_COUNT     (MISP_COUNT),
`endif
        .RES_DONE       (RES_DONE),
        .PC_SEL_OUT     (PC_SEL_OUT),
        .MISPREDICT     (MISPREDICT)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model: counters as plain ints 0..3.
    int      m_ctr [64];
    bit      m_done, m_sel, m_misp;
    longint  m_br, m_mc;

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic bit cond(input logic [2:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd3: return 1'b1;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge CLK) begin
        bit acc, tk;
        if (!RESET_N) begin
            for (int i = 0; i < 64; i++) m_ctr[i] = 1;
            m_done = 0; m_sel = 0; m_misp = 0;
            m_br = 0; m_mc = 0;
        end else begin
            acc = RES_VALID && !FLUSH && BRANCH_JUMP != 3'd2;
            tk  = cond(BRANCH_JUMP, DATA1, DATA2);
            m_done = acc;
            m_sel  = acc && tk;
            m_misp = acc && (tk != RES_PRED_TAKEN);
            if (acc && m_misp && m_mc < 64'hFFFF_FFFF) m_mc++;
            if (acc && BRANCH_JUMP != 3'd3) begin
                if (m_br < 64'hFFFF_FFFF) m_br++;
                if (tk) m_ctr[idx(RES_PC)] = (m_ctr[idx(RES_PC)] == 3) ? 3 : m_ctr[idx(RES_PC)] + 1;
                else    m_ctr[idx(RES_PC)] = (m_ctr[idx(RES_PC)] == 0) ? 0 : m_ctr[idx(RES_PC)] - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("sb_done", {31'd0, RES_DONE},   {31'd0, m_done});
            chk("sb_sel",  {31'd0, PC_SEL_OUT}, {31'd0, m_sel});
            chk("sb_misp", {31'd0, MISPREDICT}, {31'd0, m_misp});
            chk("sb_pred", {31'd0, PRED_TAKEN}, {31'd0, m_ctr[idx(PRED_PC)] >= 2});
`ifdef BRU_PERF_CNT_EN
            chk("sb_brcnt", BR_COUNT,   m_br[31:0]);
            chk("sb_mpcnt", MISP_COUNT, m_mc[31:0]);
`endif
        end
    end

    // Called at posedge+4; returns at posedge+4 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit pt, input bit fl);
        BRANCH_JUMP = op; RES_PC = pc; DATA1 = a; DATA2 = b;
        RES_PRED_TAKEN = pt; FLUSH = fl; RES_VALID = 1'b1;
        @(posedge CLK); #2;
        RES_VALID = 1'b0; FLUSH = 1'b0; BRANCH_JUMP = 3'd2;
        #2;
    endtask

    task automatic outs(input string nm, input bit d, input bit s, input bit m);
        chk({nm, "_done"}, {31'd0, RES_DONE},   {31'd0, d});
        chk({nm, "_sel"},  {31'd0, PC_SEL_OUT}, {31'd0, s});
        chk({nm, "_misp"}, {31'd0, MISPREDICT}, {31'd0, m});
    endtask

    task automatic pred(input string nm, input logic [31:0] pc, input bit e);
        PRED_PC = pc; #1;
        chk(nm, {31'd0, PRED_TAKEN}, {31'd0, e});
    endtask

    initial begin
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        chk_en = 1'b1;
        #2 RESET_N = 1'b1; #2;
        outs("rst", 0, 0, 0);
        pred("rst_pred40", 32'h40, 0);

        issue(3'd4, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 0);
        outs("blt", 1, 1, 1);
        pred("blt_pred40", 32'h40, 1);

        issue(3'd6, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 0);
        outs("bltu", 1, 0, 0);
        issue(3'd7, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 0);
        outs("bgeu", 1, 1, 1);
        issue(3'd5, 32'h40, 32'd5, 32'd5, 1, 0);
        outs("bge_eq", 1, 1, 0);

        issue(3'd0, 32'h80, 32'd7, 32'd7, 0, 0);
        pred("beq1_pred80", 32'h80, 1);
        issue(3'd0, 32'h80, 32'd7, 32'd7, 1, 0);
        issue(3'd0, 32'h80, 32'd7, 32'd7, 1, 0);
        outs("beq3", 1, 1, 0);
        issue(3'd0, 32'h80, 32'd1, 32'd2, 1, 0);
        outs("beq_nt", 1, 0, 1);
        pred("sat_pred80", 32'h80, 1);

        issue(3'd3, 32'hC0, 32'd0, 32'd0, 0, 0);
        outs("jump", 1, 1, 1);
        pred("jump_predC0", 32'hC0, 0);

        issue(3'd2, 32'hC0, 32'd0, 32'd0, 1, 0);
        outs("none", 0, 0, 0);

        issue(3'd1, 32'h100, 32'd1, 32'd2, 0, 1);
        outs("flush", 0, 0, 0);
        pred("flush_pred100", 32'h100, 0);

        // 0x40 counter is 11: one not-taken to 10, then collide to 01.
        issue(3'd0, 32'h40, 32'd1, 32'd2, 1, 0);
        PRED_PC = 32'h40;
        BRANCH_JUMP = 3'd0; RES_PC = 32'h40; DATA1 = 32'd1; DATA2 = 32'd2;
        RES_PRED_TAKEN = 1; RES_VALID = 1;
        #1 chk("coll_old", {31'd0, PRED_TAKEN}, 32'd1);
        @(posedge CLK); #2;
        RES_VALID = 0; BRANCH_JUMP = 3'd2; #2;
        chk("coll_new", {31'd0, PRED_TAKEN}, 32'd0);

        // Reset with an in-flight taken branch at 0x200.
        issue(3'd0, 32'h80, 32'd3, 32'd3, 1, 0);
        BRANCH_JUMP = 3'd0; RES_PC = 32'h200; DATA1 = 0; DATA2 = 0;
        RES_PRED_TAKEN = 0; RES_VALID = 1; RESET_N = 0;
        @(posedge CLK); #2;
        RES_VALID = 0; BRANCH_JUMP = 3'd2; RESET_N = 1; #2;
        outs("mid_rst", 0, 0, 0);
        pred("rst_pred80", 32'h80, 0);
        pred("rst_pred200", 32'h200, 0);
`ifdef BRU_PERF_CNT_EN
        chk("rst_brcnt", BR_COUNT, 32'd0);
        chk("rst_mpcnt", MISP_COUNT, 32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            issue(3'd0, 32'h300, 32'd9, 32'd9, 0, 0);
        end
        outs("last_misp", 1, 1, 1);
`ifdef BRU_PERF_CNT_EN
        chk("brcnt4", BR_COUNT, 32'd4);
        chk("mpcnt4", MISP_COUNT, 32'd4);
`endif
        repeat (2) @(posedge CLK);
        #7;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
